// File: rtl/wt_dcache_l2_stub.sv
`default_nettype none
// ============================================================================
// Module   : wt_dcache_l2_stub
// Brief    : Memory-side responder for the write-through L1 data cache
//            req/rtrn protocol, backed by a word-addressed array.
// Revision : 1.0 - initial release
// ============================================================================
// mem_data_i layout (MSB..LSB): rtype[1:0], size[2:0], paddr, nc, data[63:0], tid, amo_op[3:0]
// mem_rtrn_o layout (MSB..LSB): rtype[2:0], data[DCACHE_LINE_WIDTH-1:0], inv, tid

module wt_dcache_l2_stub #(
    parameter int unsigned NumWords          = 256,
    parameter int unsigned Latency           = 2,
    parameter int unsigned DCACHE_LINE_WIDTH = 128,
    parameter int unsigned PADDR_WIDTH       = 56,
    parameter int unsigned TID_WIDTH         = 2,
    localparam int unsigned c_REQ_W  = 2 + 3 + PADDR_WIDTH + 1 + 64 + TID_WIDTH + 4,
    localparam int unsigned c_RTRN_W = 3 + DCACHE_LINE_WIDTH + 1 + TID_WIDTH
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                mem_data_req_i,
    output logic                mem_data_ack_o,
    input  logic [c_REQ_W-1:0]  mem_data_i,
    output logic                mem_rtrn_vld_o,
    output logic [c_RTRN_W-1:0] mem_rtrn_o
);

    localparam int unsigned c_IDX_W      = $clog2(NumWords);
    localparam int unsigned c_LINE_WORDS = DCACHE_LINE_WIDTH / 64;
    localparam logic [c_IDX_W-1:0] c_BASE_MASK = c_IDX_W'(~(c_LINE_WORDS - 1));

    localparam int unsigned c_AMO_LSB   = 0;
    localparam int unsigned c_TID_LSB   = 4;
    localparam int unsigned c_DATA_LSB  = c_TID_LSB + TID_WIDTH;
    localparam int unsigned c_NC_LSB    = c_DATA_LSB + 64;
    localparam int unsigned c_PADDR_LSB = c_NC_LSB + 1;
    localparam int unsigned c_SIZE_LSB  = c_PADDR_LSB + PADDR_WIDTH;
    localparam int unsigned c_RTYPE_LSB = c_SIZE_LSB + 3;

    localparam logic [1:0] c_DCACHE_LOAD_REQ   = 2'd0;
    localparam logic [1:0] c_DCACHE_STORE_REQ  = 2'd1;
    localparam logic [1:0] c_DCACHE_ATOMIC_REQ = 2'd2;

    localparam logic [2:0] c_DCACHE_LOAD_ACK   = 3'd0;
    localparam logic [2:0] c_DCACHE_STORE_ACK  = 3'd1;
    localparam logic [2:0] c_DCACHE_ATOMIC_ACK = 3'd3;

    localparam logic [3:0] c_AMO_SWAP = 4'd3;
    localparam logic [3:0] c_AMO_ADD  = 4'd4;
    localparam logic [3:0] c_AMO_AND  = 4'd5;
    localparam logic [3:0] c_AMO_OR   = 4'd6;
    localparam logic [3:0] c_AMO_XOR  = 4'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;

    logic [1:0]             w_req_rtype;
    logic [2:0]             w_req_size;
    logic [PADDR_WIDTH-1:0] w_req_paddr;
    logic                   w_req_nc;
    logic [63:0]            w_req_data;
    logic [TID_WIDTH-1:0]   w_req_tid;
    logic [3:0]             w_req_amo;
    logic [c_IDX_W-1:0]     w_req_idx;
    logic                   w_unused;

    logic [1:0]           r_rtype;
    logic [2:0]           r_size;
    logic [2:0]           r_off;
    logic [c_IDX_W-1:0]   r_idx;
    logic [63:0]          r_data;
    logic [TID_WIDTH-1:0] r_tid;
    logic [3:0]           r_amo;

    logic [63:0] r_mem [NumWords];

    logic [1:0]                   w_src_rtype;
    logic [c_IDX_W-1:0]           w_src_idx;
    logic [TID_WIDTH-1:0]         w_src_tid;
    logic [c_IDX_W-1:0]           w_line_base;
    logic [DCACHE_LINE_WIDTH-1:0] w_line;
    logic [63:0]                  w_old_word;
    logic [2:0]                   w_rtrn_rtype;
    logic [DCACHE_LINE_WIDTH-1:0] w_rtrn_data;
    logic                         w_enter_resp;
    logic [c_RTRN_W-1:0]          r_rtrn;

    logic [7:0]  w_be_base;
    logic [7:0]  w_be;
    logic [63:0] w_store_word;
    logic        w_amo_ok;
    logic [31:0] w_a32;
    logic [31:0] w_b32;
    logic [31:0] w_r32;
    logic [63:0] w_amo_word;
    logic        w_mem_we;
    logic [63:0] w_mem_wdata;

    function automatic logic [63:0] f_amo(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
        logic [63:0] res;
        case (op)
            c_AMO_SWAP: res = b;
            c_AMO_ADD:  res = a + b;
            c_AMO_AND:  res = a & b;
            c_AMO_OR:   res = a | b;
            c_AMO_XOR:  res = a ^ b;
            default:    res = a;
        endcase
        return res;
    endfunction

    assign w_req_amo   = mem_data_i[c_AMO_LSB   +: 4];
    assign w_req_tid   = mem_data_i[c_TID_LSB   +: TID_WIDTH];
    assign w_req_data  = mem_data_i[c_DATA_LSB  +: 64];
    assign w_req_nc    = mem_data_i[c_NC_LSB];
    assign w_req_paddr = mem_data_i[c_PADDR_LSB +: PADDR_WIDTH];
    assign w_req_size  = mem_data_i[c_SIZE_LSB  +: 3];
    assign w_req_rtype = mem_data_i[c_RTYPE_LSB +: 2];
    assign w_req_idx   = w_req_paddr[3 +: c_IDX_W];

    // Non-cacheable requests behave exactly like cacheable ones; upper address bits wrap.
    assign w_unused = w_req_nc ^ (^w_req_paddr[PADDR_WIDTH-1:3+c_IDX_W]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        mem_data_ack_o = 1'b0;
        case (r_state)
            IDLE: begin
                mem_data_ack_o = mem_data_req_i;
                if (mem_data_req_i) begin
                    w_cnt_nxt   = 4'(Latency - 1);
                    w_state_nxt = (Latency == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rtype <= 2'd0;
            r_size  <= 3'd0;
            r_off   <= 3'd0;
            r_idx   <= '0;
            r_data  <= 64'd0;
            r_tid   <= '0;
            r_amo   <= 4'd0;
        end else if (mem_data_ack_o) begin
            r_rtype <= w_req_rtype;
            r_size  <= w_req_size;
            r_off   <= w_req_paddr[2:0];
            r_idx   <= w_req_idx;
            r_data  <= w_req_data;
            r_tid   <= w_req_tid;
            r_amo   <= w_req_amo;
        end
    end

    // With Latency==1 the response is formed in the accepting IDLE cycle, before the latch.
    assign w_src_rtype  = (r_state == IDLE) ? w_req_rtype : r_rtype;
    assign w_src_idx    = (r_state == IDLE) ? w_req_idx   : r_idx;
    assign w_src_tid    = (r_state == IDLE) ? w_req_tid   : r_tid;
    assign w_line_base  = w_src_idx & c_BASE_MASK;
    assign w_old_word   = r_mem[w_src_idx];
    assign w_enter_resp = (w_state_nxt == RESP) && (r_state != RESP);

    always_comb begin
        w_line = '0;
        for (int k = 0; k < c_LINE_WORDS; k++) begin
            w_line[k*64 +: 64] = r_mem[w_line_base + c_IDX_W'(k)];
        end
    end

    always_comb begin
        w_rtrn_rtype = c_DCACHE_LOAD_ACK;
        w_rtrn_data  = w_line;
        case (w_src_rtype)
            c_DCACHE_STORE_REQ: begin
                w_rtrn_rtype = c_DCACHE_STORE_ACK;
                w_rtrn_data  = '0;
            end
            c_DCACHE_ATOMIC_REQ: begin
                w_rtrn_rtype = c_DCACHE_ATOMIC_ACK;
                w_rtrn_data  = {c_LINE_WORDS{w_old_word}};
            end
            default: begin
                w_rtrn_rtype = c_DCACHE_LOAD_ACK;
                w_rtrn_data  = w_line;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rtrn <= '0;
        end else if (w_enter_resp) begin
            r_rtrn <= {w_rtrn_rtype, w_rtrn_data, 1'b0, w_src_tid};
        end
    end

    assign mem_rtrn_o     = r_rtrn;
    assign mem_rtrn_vld_o = (r_state == RESP);

    always_comb begin
        case (r_size)
            3'd0:    w_be_base = 8'h01;
            3'd1:    w_be_base = 8'h03;
            3'd2:    w_be_base = 8'h0F;
            default: w_be_base = 8'hFF;
        endcase
        // Bytes shifted past the top of the word are dropped on misaligned stores.
        w_be = w_be_base << r_off;
        for (int b = 0; b < 8; b++) begin
            w_store_word[b*8 +: 8] = w_be[b] ? r_data[b*8 +: 8] : w_old_word[b*8 +: 8];
        end
    end

    always_comb begin
        w_amo_ok = (r_amo == c_AMO_SWAP) || (r_amo == c_AMO_ADD) || (r_amo == c_AMO_AND) ||
                   (r_amo == c_AMO_OR)   || (r_amo == c_AMO_XOR);
        w_a32      = r_off[2] ? w_old_word[63:32] : w_old_word[31:0];
        w_b32      = r_off[2] ? r_data[63:32]     : r_data[31:0];
        w_r32      = 32'(f_amo(r_amo, {32'd0, w_a32}, {32'd0, w_b32}));
        w_amo_word = f_amo(r_amo, w_old_word, r_data);
        if (r_size == 3'd2) begin
            w_amo_word = r_off[2] ? {w_r32, w_old_word[31:0]} : {w_old_word[63:32], w_r32};
        end
    end

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_wdata = w_store_word;
        case (r_rtype)
            c_DCACHE_STORE_REQ: begin
                w_mem_we    = 1'b1;
                w_mem_wdata = w_store_word;
            end
            c_DCACHE_ATOMIC_REQ: begin
                w_mem_we    = w_amo_ok;
                w_mem_wdata = w_amo_word;
            end
            default: w_mem_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumWords; i++) begin
                r_mem[i] <= 64'd0;
            end
        end else if ((r_state == RESP) && w_mem_we) begin
            r_mem[r_idx] <= w_mem_wdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wt_dcache_l2_stub.sv
`default_nettype none
// ============================================================================
// Module   : tb_wt_dcache_l2_stub
// Brief    : Directed self-checking bench for wt_dcache_l2_stub.
// Revision : 1.0 - initial release
// ============================================================================

module tb_wt_dcache_l2_stub;

    localparam int c_LAT  = 2;
    localparam int c_TIDW = 2;
    localparam int c_PAW  = 56;
    localparam int c_LW   = 128;
    localparam int c_REQW = 2 + 3 + c_PAW + 1 + 64 + c_TIDW + 4;
    localparam int c_RTW  = 3 + c_LW + 1 + c_TIDW;

    localparam logic [1:0] c_RT_LOAD  = 2'd0;
    localparam logic [1:0] c_RT_STORE = 2'd1;
    localparam logic [1:0] c_RT_AMO   = 2'd2;
    localparam logic [2:0] c_ACK_LOAD = 3'd0;
    localparam logic [2:0] c_ACK_ST   = 3'd1;
    localparam logic [2:0] c_ACK_AMO  = 3'd3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req = 1'b0;
    logic              ack;
    logic              vld;
    logic [c_REQW-1:0] req_d = '0;
    logic [c_RTW-1:0]  rtrn;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wt_dcache_l2_stub #(
        .NumWords          (256),
        .Latency           (c_LAT),
        .DCACHE_LINE_WIDTH (c_LW),
        .PADDR_WIDTH       (c_PAW),
        .TID_WIDTH         (c_TIDW)
    ) u_dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .mem_data_req_i (req),
        .mem_data_ack_o (ack),
        .mem_data_i     (req_d),
        .mem_rtrn_vld_o (vld),
        .mem_rtrn_o     (rtrn)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic [1:0] rt, input logic [2:0] sz, input logic [c_PAW-1:0] pa,
                           input logic [63:0] d, input logic [c_TIDW-1:0] t, input logic [3:0] amo);
        req_d = {rt, sz, pa, 1'b0, d, t, amo};
    endtask

    task automatic do_req(input string tag, input logic [1:0] rt, input logic [2:0] sz,
                          input logic [c_PAW-1:0] pa, input logic [63:0] d,
                          input logic [c_TIDW-1:0] t, input logic [3:0] amo,
                          input logic [2:0] ert, input logic [c_LW-1:0] edata);
        @(negedge clk);
        set_req(rt, sz, pa, d, t, amo);
        req = 1'b1;
        #1 chk({tag, " ack"}, 128'(ack), 128'(1));
        @(posedge clk);
        #1 req = 1'b0;
        for (int i = 1; i <= c_LAT; i++) begin
            @(negedge clk);
            #1 chk({tag, " vld"}, 128'(vld), 128'(i == c_LAT));
        end
        chk({tag, " rtype"}, 128'(rtrn[c_RTW-1 -: 3]), 128'(ert));
        chk({tag, " tid"},   128'(rtrn[c_TIDW-1:0]),   128'(t));
        chk({tag, " inv"},   128'(rtrn[c_TIDW]),       128'(0));
        chk({tag, " data"},  rtrn[c_TIDW+1 +: c_LW],   edata);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("reset ack", 128'(ack), 128'(0));
        chk("reset vld", 128'(vld), 128'(0));
        chk("reset rtrn", 128'(|rtrn), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1 chk("post-reset vld", 128'(vld), 128'(0));

        do_req("ld40", c_RT_LOAD, 3'd3, 56'h40, 64'h0, 2'd3, 4'd0, c_ACK_LOAD, '0);
        @(negedge clk);
        #1 chk("ld40 hold vld", 128'(vld), 128'(0));
        chk("ld40 hold tid", 128'(rtrn[c_TIDW-1:0]), 128'(3));

        do_req("st18", c_RT_STORE, 3'd3, 56'h18, 64'h1122334455667788, 2'd1, 4'd0, c_ACK_ST, '0);
        do_req("ld10", c_RT_LOAD, 3'd3, 56'h10, 64'h0, 2'd2, 4'd0, c_ACK_LOAD,
               {64'h1122334455667788, 64'h0});
        do_req("st1b", c_RT_STORE, 3'd0, 56'h1B, 64'hFFFFFFFFABFFFFFF, 2'd0, 4'd0, c_ACK_ST, '0);
        do_req("ld18", c_RT_LOAD, 3'd3, 56'h18, 64'h0, 2'd1, 4'd0, c_ACK_LOAD,
               {64'h11223344AB667788, 64'h0});
        do_req("st12", c_RT_STORE, 3'd1, 56'h12, 64'hFFFFFFFFBEEFFFFF, 2'd2, 4'd0, c_ACK_ST, '0);
        do_req("st14", c_RT_STORE, 3'd2, 56'h14, 64'hCAFEBABEFFFFFFFF, 2'd3, 4'd0, c_ACK_ST, '0);
        do_req("ld10b", c_RT_LOAD, 3'd3, 56'h10, 64'h0, 2'd0, 4'd0, c_ACK_LOAD,
               {64'h11223344AB667788, 64'hCAFEBABEBEEF0000});

        // Atomics: old word comes back in every lane.
        do_req("st20", c_RT_STORE, 3'd3, 56'h20, 64'hFFFFFFFF00000005, 2'd1, 4'd0, c_ACK_ST, '0);
        do_req("add24", c_RT_AMO, 3'd2, 56'h24, 64'h0000000112345678, 2'd2, 4'd4, c_ACK_AMO,
               {2{64'hFFFFFFFF00000005}});
        do_req("ld20", c_RT_LOAD, 3'd3, 56'h20, 64'h0, 2'd3, 4'd0, c_ACK_LOAD,
               {64'h0, 64'h0000000000000005});
        do_req("swap28", c_RT_AMO, 3'd3, 56'h28, 64'hDEAD, 2'd0, 4'd3, c_ACK_AMO, '0);
        do_req("xor28", c_RT_AMO, 3'd3, 56'h28, 64'hFFFF, 2'd1, 4'd7, c_ACK_AMO, {2{64'hDEAD}});
        do_req("and20", c_RT_AMO, 3'd2, 56'h20, 64'h4, 2'd2, 4'd5, c_ACK_AMO, {2{64'h5}});
        do_req("or24", c_RT_AMO, 3'd2, 56'h24, 64'hF000000000000000, 2'd3, 4'd6, c_ACK_AMO,
               {2{64'h4}});
        do_req("lr28", c_RT_AMO, 3'd3, 56'h28, 64'h1234, 2'd0, 4'd1, c_ACK_AMO, {2{64'h2152}});
        do_req("ld20b", c_RT_LOAD, 3'd3, 56'h20, 64'h0, 2'd1, 4'd0, c_ACK_LOAD,
               {64'h2152, 64'hF000000000000004});

        // Address bits above the array index wrap: 0x830 aliases 0x30.
        do_req("st830", c_RT_STORE, 3'd3, 56'h830, 64'h77, 2'd2, 4'd0, c_ACK_ST, '0);
        do_req("ld30", c_RT_LOAD, 3'd3, 56'h30, 64'h0, 2'd3, 4'd0, c_ACK_LOAD, {64'h0, 64'h77});

        // Request held high across three transactions.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) begin
                set_req(c_RT_LOAD, 3'd3, 56'h0, 64'h0, 2'd0, 4'd0);
                req = 1'b1;
            end else if (c == 1 || c == 4) begin
                req_d[4 +: c_TIDW] = req_d[4 +: c_TIDW] + 1'b1;
            end else if (c == 7) begin
                req = 1'b0;
            end
            #1;
            chk($sformatf("held ack c%0d", c), 128'(ack), 128'(c == 0 || c == 3 || c == 6));
            chk($sformatf("held vld c%0d", c), 128'(vld), 128'(c == 2 || c == 5 || c == 8));
            if (c == 2 || c == 5 || c == 8) begin
                chk($sformatf("held tid c%0d", c), 128'(rtrn[c_TIDW-1:0]), 128'((c - 2) / 3));
            end
        end

        // Reset while the store is waiting: it must never land.
        @(negedge clk);
        set_req(c_RT_STORE, 3'd3, 56'h38, 64'h99, 2'd1, 4'd0);
        req = 1'b1;
        #1 chk("rst ack", 128'(ack), 128'(1));
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("rst vld", 128'(vld), 128'(0));
        chk("rst rtrn", 128'(|rtrn), 128'(0));
        repeat (3) begin
            @(negedge clk);
            #1 chk("rst hold vld", 128'(vld), 128'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1 chk("rst release vld", 128'(vld), 128'(0));
        end
        do_req("ld38", c_RT_LOAD, 3'd3, 56'h38, 64'h0, 2'd3, 4'd0, c_ACK_LOAD, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
